data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 101 ++++++++++
 tb/tb_data_mem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder with WAIT_CYCLES wait states and a one-cycle ready pulse.
// Optional misaligned-access checking is enabled by defining ALIGN_CHECK_EN.
module data_mem_responder #(
   parameter int DEPTH_LOG2  = 6,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] datain,
   output logic [31:0] dataout,
   output logic        ready,
   output logic        busy,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic                  wr_q;
   logic                  mis_q;
   logic                  err_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [31:0]           wdata_q;
   logic [31:0]           dout_q;
   logic                  ready_q;
   logic [31:0]           mem_q [0:(1<<DEPTH_LOG2)-1];

   logic                  mis_d;
   logic                  op_now;
   logic                  mem_we;

`ifdef ALIGN_CHECK_EN
   assign mis_d = (addr[1:0] != 2'b00);
`else
   assign mis_d = 1'b0;
`endif

   // Upper address bits wrap; the low byte-lane bits only matter with alignment checking.
   logic unused_addr;
   assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

   assign op_now = (state_q == WAIT) && (cnt_q == 4'd0);
   assign mem_we = Reset && op_now && wr_q && !mis_q;

   always_ff @(posedge Clock) begin
      if (mem_we) mem_q[idx_q] <= wdata_q;
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         dout_q  <= 32'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
         mis_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= 1'b0;
               err_q   <= 1'b0;
               if (read || write) begin
                  wr_q    <= write;
                  mis_q   <= mis_d;
                  idx_q   <= addr[DEPTH_LOG2+1:2];
                  wdata_q <= datain;
                  cnt_q   <= WAIT_CYCLES[3:0];
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  ready_q <= 1'b1;
                  err_q   <= mis_q;
                  if (!wr_q) dout_q <= mis_q ? 32'd0 : mem_q[idx_q];
                  state_q <= RESP;
               end
            end
            RESP: begin
               ready_q <= 1'b0;
               err_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dataout = dout_q;
   assign ready   = ready_q;
   assign err     = err_q;
   assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: driver pushes expected responses, monitor checks each ready pulse.
module tb_data_mem_responder;
   localparam int DL    = 6;
   localparam int WC    = 2;
   localparam int DEPTH = 1 << DL;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        read = 1'b0, write = 1'b0;
   logic [31:0] addr = 32'd0, datain = 32'd0;
   logic [31:0] dataout;
   logic        ready, busy, err;

   always #5 Clock = ~Clock;

   data_mem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WC)) dut (
      .Clock(Clock), .Reset(Reset), .read(read), .write(write), .addr(addr),
      .datain(datain), .dataout(dataout), .ready(ready), .busy(busy), .err(err)
   );

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mmem [DEPTH];
   logic [31:0] mdout;
   int          cyc = 0;
   int          nchk = 0, nerr = 0;
   bit          in_resp = 1'b0;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every ready pulse must match the oldest outstanding expectation.
   always @(negedge Clock) begin
      if (Reset) begin
         if (ready) begin
            if (q.size() == 0) begin
               nchk++; nerr++;
               $display("FAIL spurious_ready: got ready=1 expected none (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("ready_cycle", cyc, e.cyc);
               chk("dataout", dataout, e.data);
               chk("err", {31'd0, err}, {31'd0, e.err});
            end
         end else if (q.size() != 0 && cyc > q[0].cyc) begin
            nchk++; nerr++;
            $display("FAIL ready_timeout: got no ready expected at cycle %0d (now %0d)", q[0].cyc, cyc);
            void'(q.pop_front());
         end
      end
   end

   // Called at a negedge; if in_resp, the DUT is in its ready cycle and accepts one edge later.
   task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      exp_t        e;
      int unsigned ix;
      bit          mis;
      ix = (a >> 2) % DEPTH;
`ifdef ALIGN_CHECK_EN
      mis = (a[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      if (wr) begin
         if (!mis) mmem[ix] = d;
      end else begin
         mdout = mis ? 32'd0 : mmem[ix];
      end
      e.cyc  = cyc + (in_resp ? 2 : 1) + WC + 1;
      e.data = mdout;
      e.err  = mis;
      q.push_back(e);
      read = rd; write = wr; addr = a; datain = d;
      for (int i = 0; i < WC + 8; i++) begin
         @(negedge Clock);
         if (i == 0 && !in_resp) chk("busy_after_accept", {31'd0, busy}, 32'd1);
         if (ready) break;
      end
      in_resp = 1'b1;
   endtask

   task automatic idle(input int n);
      read = 1'b0; write = 1'b0;
      repeat (n) @(negedge Clock);
      if (n > 0) begin
         in_resp = 1'b0;
         chk("busy_idle", {31'd0, busy}, 32'd0);
         chk("ready_pulse", {31'd0, ready}, 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish by 200000");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a;
      int          op;
      Reset = 1'b0;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      chk("rst_dataout", dataout, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      Reset = 1'b1;
      mdout = 32'd0;
      foreach (mmem[i]) mmem[i] = 32'd0;
      @(negedge Clock);

      // Known memory contents regardless of simulator initialisation.
      for (int i = 0; i < DEPTH; i++) begin
         issue(1'b0, 1'b1, i * 4, 32'd0);
         idle(1);
      end

      issue(1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF); idle(1);
      issue(1'b1, 1'b0, 32'h0000_0008, 32'd0);         idle(1);

      issue(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678); idle(1);
      issue(1'b1, 1'b0, 32'h0000_0010, 32'd0);         idle(1);

      // Back-to-back: next request driven during the ready cycle.
      issue(1'b0, 1'b1, 32'h0000_0004, 32'hA5A5_0001);
      issue(1'b1, 1'b0, 32'h0000_0104, 32'd0);
      idle(2);

      // Reset during WAIT drops the write.
      read = 1'b0; write = 1'b1; addr = 32'h0000_0020; datain = 32'h5555_AAAA;
      @(negedge Clock);
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      Reset = 1'b0;
      @(negedge Clock);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_ready", {31'd0, ready}, 32'd0);
      chk("abort_dataout", dataout, 32'd0);
      mdout = 32'd0;
      Reset = 1'b1; write = 1'b0;
      @(negedge Clock);
      in_resp = 1'b0;
      issue(1'b1, 1'b0, 32'h0000_0020, 32'd0); idle(1);

      issue(1'b0, 1'b1, 32'h0000_0022, 32'hCAFE_F00D); idle(1);
      issue(1'b1, 1'b0, 32'h0000_0020, 32'd0);         idle(1);

      for (int n = 0; n < 150; n++) begin
         op = $urandom_range(0, 2);
         a  = $urandom;
         if ($urandom_range(0, 1) == 1) a[31:8] = 24'd0;
         issue(op != 1, op != 0, a, $urandom);
         idle($urandom_range(0, 2));
      end
      idle(2);

      repeat (WC + 6) @(negedge Clock);
      if (q.size() != 0) begin
         nchk++; nerr++;
         $display("FAIL drain: got %0d outstanding expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
